// File: rtl/addsub_pkg.sv
// Shared constants and arithmetic helpers for the shared add/subtract arbiter.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the helpers support; narrower operands are sign-extended into it.
    localparam int MAX_DW = 32;

    typedef logic signed [MAX_DW:0] wide_t;

    // Ceiling log2, with a minimum result of 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Signed add/subtract of dw-bit operands (sign-extended into MAX_DW bits).
    // Returns {ovf, data}. The sum is formed one bit wider than the operands,
    // so subtracting the most negative value is never negated in dw bits.
    // Being outside the dw-bit range is the same condition as the top two
    // bits of the dw+1-bit result disagreeing.
    function automatic logic [MAX_DW:0] sat_add(
        input logic signed [MAX_DW-1:0] a,
        input logic signed [MAX_DW-1:0] b,
        input logic                     op,
        input int                       dw,
        input logic                     sat_en
    );
        wide_t             wa;
        wide_t             wb;
        wide_t             full;
        wide_t             hi;
        wide_t             lo;
        wide_t             one;
        logic              ovf;
        logic [MAX_DW-1:0] data;

        wa   = wide_t'(a);
        wb   = wide_t'(b);
        one  = wide_t'(1);
        hi   = (one <<< (dw - 1)) - one;
        lo   = -(one <<< (dw - 1));
        full = (op == OP_SUB) ? (wa - wb) : (wa + wb);
        ovf  = (full > hi) || (full < lo);
        data = full[MAX_DW-1:0];
        if (ovf && sat_en) begin
            data = full[MAX_DW] ? lo[MAX_DW-1:0] : hi[MAX_DW-1:0];
        end
        return {ovf, data};
    endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/result bundle between the requesters and the shared add/subtract unit.
//
// Handshake: requester i holds req_valid[i] together with req_op/req_a/req_b
// slice i; the arbiter raises at most one req_ready bit per cycle. A transfer
// happens on the rising edge where req_valid[i] & req_ready[i]. There is no
// result back-pressure: res_valid is a one-cycle strobe per accepted operation,
// and res_data/res_id/res_ovf are only meaningful while it is high.
interface addsub_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 16
);
    localparam int IW = addsub_pkg::clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    req_op;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ-1:0]    req_mask;
    logic                res_valid;
    logic [DW-1:0]       res_data;
    logic [IW-1:0]       res_id;
    logic                res_ovf;
    logic                busy;

    modport master (
        output req_valid,
        output req_op,
        output req_a,
        output req_b,
        output req_mask,
        input  req_ready,
        input  res_valid,
        input  res_data,
        input  res_id,
        input  res_ovf,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_a,
        input  req_b,
        input  req_mask,
        output req_ready,
        output res_valid,
        output res_data,
        output res_id,
        output res_ovf,
        output busy
    );

endinterface

// File: rtl/addsub_sat_pipe.sv
// Two-stage signed add/subtract pipeline with optional saturation.
// Stage 1 captures the accepted operation; stage 2 computes and registers the result.
module addsub_sat_pipe
    import addsub_pkg::*;
#(
    parameter int DW     = 16,
    parameter int IW     = 2,
    parameter bit SAT_EN = 1'b1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_op,
    input  logic [IW-1:0] in_id,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [IW-1:0] res_id,
    output logic          res_ovf,
    output logic          busy
);

    logic                 s1_v;
    logic signed [DW-1:0] s1_a;
    logic signed [DW-1:0] s1_b;
    logic                 s1_op;
    logic [IW-1:0]        s1_id;
    logic [MAX_DW:0]      sat_out;

    // Stage 1: latch operands only on an accepted transfer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= OP_ADD;
            s1_id <= '0;
        end else begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= in_op;
                s1_id <= in_id;
            end
        end
    end

    // Widened arithmetic on the stage-1 operands.
    always_comb begin
        sat_out = sat_add(MAX_DW'(s1_a), MAX_DW'(s1_b), s1_op, DW, SAT_EN);
    end

    // Stage 2: register the result; data fields hold when no result is produced.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_ovf   <= 1'b0;
        end else begin
            res_valid <= s1_v;
            if (s1_v) begin
                res_data <= sat_out[DW-1:0];
                res_ovf  <= sat_out[MAX_DW];
                res_id   <= s1_id;
            end
        end
    end

    assign busy = s1_v | res_valid;

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one pipelined saturating add/subtract unit
// among N_REQ requesters.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DW     = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    addsub_arbiter_if.slave  bus
);

    localparam int IW = clog2(N_REQ);

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic             found;
    logic [IW-1:0]    gid;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_next;
    logic             accept;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;
    logic             sel_op;
    int               idx;

    assign elig = bus.req_valid & bus.req_mask;

    // Search the eligible set starting at the pointer; the first hit wins.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                gid        = IW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Reset overrides any grant so nothing is accepted while it is high.
    assign bus.req_ready = Reset ? '0 : grant;
    assign accept        = found & ~Reset;
    assign ptr_next      = (int'(gid) == N_REQ - 1) ? '0 : gid + 1'b1;

    // Operand selection for the granted requester.
    always_comb begin
        sel_a  = bus.req_a[int'(gid)*DW +: DW];
        sel_b  = bus.req_b[int'(gid)*DW +: DW];
        sel_op = bus.req_op[gid];
    end

    // Pointer moves just past the winner; it holds when nothing is accepted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end

    addsub_sat_pipe #(
        .DW     (DW),
        .IW     (IW),
        .SAT_EN (SAT_EN)
    ) u_pipe (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (accept),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .in_op     (sel_op),
        .in_id     (gid),
        .res_valid (bus.res_valid),
        .res_data  (bus.res_data),
        .res_id    (bus.res_id),
        .res_ovf   (bus.res_ovf),
        .busy      (bus.busy)
    );

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: grant order, latency, saturation/wrap,
// masking and mid-operation reset, with a result scoreboard.
module tb_addsub_arbiter;
    import addsub_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int W  = IW + 1 + DW;

    logic Clk;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    addsub_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();
    addsub_arbiter_if #(.N_REQ(N), .DW(DW)) wbus ();

    addsub_arbiter #(.N_REQ(N), .DW(DW), .SAT_EN(1'b1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    addsub_arbiter #(.N_REQ(N), .DW(DW), .SAT_EN(1'b0)) dut_wrap (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (wbus)
    );

    // Clock and watchdog
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks++;
        assert (obs === exp_val) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_val);
        end
    endtask

    // Reference result: {id, ovf, data}
    function automatic logic [W-1:0] model(input int id, input logic op,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input bit sat);
        int            sa;
        int            sb;
        int            full;
        logic [31:0]   fv;
        logic          ovf;
        logic [DW-1:0] d;
        logic [31:0]   idw;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        full = op ? (sa - sb) : (sa + sb);
        ovf  = (full > 32767) || (full < -32768);
        fv   = full;
        d    = fv[DW-1:0];
        if (ovf && sat) d = (full > 0) ? 16'h7FFF : 16'h8000;
        idw  = id;
        return {idw[IW-1:0], ovf, d};
    endfunction

    // Scoreboard: push on observed handshake, pop and compare on res_valid.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_pending", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("sb_result", 32'({bus.res_id, bus.res_ovf, bus.res_data}), 32'(exp_v));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back(model(i, bus.req_op[i], bus.req_a[i*DW +: DW],
                                          bus.req_b[i*DW +: DW], 1'b1));
                end
            end
        end
    end

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*DW +: DW] = 16'($urandom_range(0, 65535));
            bus.req_b[i*DW +: DW] = 16'($urandom_range(0, 65535));
            bus.req_op[i]         = 1'($urandom_range(0, 1));
        end
    endtask

    // Present one operation on requester i and hold it until accepted.
    task automatic issue(input int i, input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic got;
        @(posedge Clk); #1;
        bus.req_op[i]         = op;
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
        bus.req_valid         = '0;
        bus.req_valid[i]      = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge Clk);
            if (bus.req_ready[i]) got = 1'b1;
            else begin
                @(posedge Clk); #1;
            end
        end
        check("issue_grant", 32'(got), 32'd1);
        @(posedge Clk); #1;
        bus.req_valid = '0;
    endtask

    initial begin
        // Reset block
        Reset          = 1'b1;
        bus.req_valid  = 4'hF;
        bus.req_mask   = 4'hF;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        wbus.req_valid = '0;
        wbus.req_mask  = 4'hF;
        wbus.req_op    = '0;
        wbus.req_a     = '0;
        wbus.req_b     = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        check("rst_res_ovf", 32'(bus.res_ovf), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge Clk); #1;
        Reset         = 1'b0;
        bus.req_valid = '0;

        // Single add, latency T+2
        issue(0, OP_ADD, 16'd1000, 16'd234);
        @(negedge Clk);
        check("add_lat_early", 32'(bus.res_valid), 32'd0);
        check("add_busy", 32'(bus.busy), 32'd1);
        @(negedge Clk);
        check("add_valid", 32'(bus.res_valid), 32'd1);
        check("add_data", 32'(bus.res_data), 32'd1234);
        check("add_id", 32'(bus.res_id), 32'd0);
        check("add_ovf", 32'(bus.res_ovf), 32'd0);

        // Saturation: positive and negative clamp
        issue(1, OP_ADD, 16'd30000, 16'd10000);
        @(negedge Clk);
        @(negedge Clk);
        check("satp_data", 32'(bus.res_data), 32'h7FFF);
        check("satp_ovf", 32'(bus.res_ovf), 32'd1);
        check("satp_id", 32'(bus.res_id), 32'd1);
        issue(2, OP_SUB, 16'h8AD0, 16'd10000);
        @(negedge Clk);
        @(negedge Clk);
        check("satn_data", 32'(bus.res_data), 32'h8000);
        check("satn_ovf", 32'(bus.res_ovf), 32'd1);

        // Pointer at 3, only 1 and 3 valid: grant 3 then 1
        @(posedge Clk); #1;
        rand_ops();
        bus.req_valid = 4'b1010;
        @(negedge Clk);
        check("wrap_first", 32'(bus.req_ready), 32'b1000);
        @(posedge Clk); #1;
        bus.req_valid = 4'b0010;
        @(negedge Clk);
        check("wrap_second", 32'(bus.req_ready), 32'b0010);
        @(posedge Clk); #1;
        rand_ops();
        bus.req_valid = 4'b0111;
        @(negedge Clk);
        check("ptr_is_2", 32'(bus.req_ready), 32'b0100);
        @(posedge Clk); #1;
        bus.req_valid = '0;

        // Subtracting the most negative value
        issue(3, OP_SUB, 16'd0, 16'h8000);
        @(negedge Clk);
        @(negedge Clk);
        check("submin_data", 32'(bus.res_data), 32'h7FFF);
        check("submin_ovf", 32'(bus.res_ovf), 32'd1);

        // Wrap mode on the second instance
        @(posedge Clk); #1;
        wbus.req_a[DW-1:0] = 16'd30000;
        wbus.req_b[DW-1:0] = 16'd10000;
        wbus.req_op[0]     = OP_ADD;
        wbus.req_valid     = 4'b0001;
        @(negedge Clk);
        check("wr_ready", 32'(wbus.req_ready), 32'b0001);
        @(posedge Clk); #1;
        wbus.req_valid = '0;
        @(negedge Clk);
        @(negedge Clk);
        check("wr_valid", 32'(wbus.res_valid), 32'd1);
        check("wr_data", 32'(wbus.res_data), 32'h9C40);
        check("wr_ovf", 32'(wbus.res_ovf), 32'd1);

        // Mask blocks requester 2 until re-enabled
        @(posedge Clk); #1;
        rand_ops();
        bus.req_mask  = 4'b1011;
        bus.req_valid = 4'b0100;
        repeat (3) begin
            @(negedge Clk);
            check("mask_block", 32'(bus.req_ready), 32'd0);
        end
        @(posedge Clk); #1;
        bus.req_mask = 4'hF;
        @(negedge Clk);
        check("mask_grant", 32'(bus.req_ready), 32'b0100);
        @(posedge Clk); #1;
        bus.req_valid = '0;
        @(negedge Clk);
        check("mask_lat_early", 32'(bus.res_valid), 32'd0);
        @(negedge Clk);
        check("mask_res_valid", 32'(bus.res_valid), 32'd1);
        check("mask_res_id", 32'(bus.res_id), 32'd2);

        // Bring pointer to 0, then all four valid continuously
        issue(3, OP_ADD, 16'd5, 16'd7);
        @(posedge Clk); #1;
        rand_ops();
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            check("rr_order", 32'(bus.req_ready), 32'(1 << (k % 4)));
            @(posedge Clk); #1;
            rand_ops();
        end
        bus.req_valid = '0;

        // Reset while an operation is in stage 1
        issue(2, OP_ADD, 16'd11, 16'd22);
        Reset         = 1'b1;
        bus.req_valid = 4'hF;
        exp_q.delete();
        @(negedge Clk);
        check("rst_force_ready", 32'(bus.req_ready), 32'd0);
        @(posedge Clk); #1;
        Reset         = 1'b0;
        bus.req_valid = '0;
        @(negedge Clk);
        check("rst2_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst2_res_data", 32'(bus.res_data), 32'd0);
        check("rst2_res_id", 32'(bus.res_id), 32'd0);
        check("rst2_res_ovf", 32'(bus.res_ovf), 32'd0);
        check("rst2_busy", 32'(bus.busy), 32'd0);
        @(posedge Clk); #1;
        rand_ops();
        bus.req_valid = 4'b1100;
        @(negedge Clk);
        check("rst2_ptr", 32'(bus.req_ready), 32'b0100);
        @(posedge Clk); #1;
        bus.req_valid = '0;

        // Drain
        repeat (4) @(negedge Clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("end_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
